// File: rtl/cmd_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : cmd_wb_master
// Description : Byte-stream command decoder that issues single Wishbone B4
//               pipelined transfers and returns read data or timeout status.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_wb_master #(
    parameter int WB_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic [DATA_WIDTH-1:0]    cmd_data_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic [DATA_WIDTH-1:0]    rsp_data_o,
    output logic                     rsp_valid_o,
    output logic                     rsp_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i
);

    localparam int c_TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR_HI  = 3'd1,
        S_ADDR_LO  = 3'd2,
        S_DATA     = 3'd3,
        S_STROBE   = 3'd4,
        S_WAIT_ACK = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [c_TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     ready_en_q, ready_en_d;

    logic w_cmd_ready;
    logic w_accept;
    logic w_in_bus;
    logic w_complete;
    logic w_timeout;
    logic w_unused;

    // Opcode bits [5:4] carry no meaning.
    assign w_unused = &{1'b0, cmd_data_i[5:4]};

    // ready_en_q keeps cmd_ready_o low until the first edge after reset release.
    assign w_cmd_ready = ready_en_q && (state_q == S_IDLE || state_q == S_ADDR_HI ||
                                        state_q == S_ADDR_LO || state_q == S_DATA);
    assign w_accept    = cmd_valid_i && w_cmd_ready;
    assign w_in_bus    = (state_q == S_STROBE) || (state_q == S_WAIT_ACK);
    assign w_complete  = ((state_q == S_STROBE) && !wb_stall_i && wb_ack_i) ||
                         ((state_q == S_WAIT_ACK) && wb_ack_i);
    assign w_timeout   = w_in_bus && !w_complete && (tmo_cnt_q == c_TMO_LAST);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        wdata_d     = wdata_q;
        tmo_cnt_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        ready_en_d  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d = cmd_data_i[6];
                    if (cmd_data_i[7]) begin
                        addr_d  = last_addr_q + WB_ADDR_WIDTH'(1);
                        state_d = cmd_data_i[6] ? S_DATA : S_STROBE;
                    end else begin
                        addr_d[19:16] = cmd_data_i[3:0];
                        state_d       = S_ADDR_HI;
                    end
                end
            end
            S_ADDR_HI: begin
                if (w_accept) begin
                    addr_d[15:8] = cmd_data_i[7:0];
                    state_d      = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (w_accept) begin
                    addr_d[7:0] = cmd_data_i[7:0];
                    state_d     = we_q ? S_DATA : S_STROBE;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    wdata_d = cmd_data_i;
                    state_d = S_STROBE;
                end
            end
            S_STROBE, S_WAIT_ACK: begin
                if (w_complete) begin
                    state_d     = S_IDLE;
                    last_addr_d = addr_q;
                    if (!we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = wb_data_i;
                    end
                end else if (w_timeout) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                    if (state_q == S_STROBE && !wb_stall_i) begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            last_addr_q <= '0;
            wdata_q     <= '0;
            tmo_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            wdata_q     <= wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign cmd_ready_o = w_cmd_ready;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_cycle_o  = w_in_bus;
    assign wb_strobe_o = (state_q == S_STROBE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_wb_master
// Description : Directed bench for cmd_wb_master with a transaction-level
//               model (expected transfer / response queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [19:0] wb_addr_o;
    logic [7:0]  wb_data_o;
    logic [7:0]  wb_data_i = 8'h00;
    logic        wb_we_o;
    logic        wb_cycle_o;
    logic        wb_strobe_o;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    cmd_wb_master #(
        .WB_ADDR_WIDTH(20),
        .DATA_WIDTH   (8),
        .ACK_TIMEOUT  (255)
    ) dut (
        .wb_clock_i (clk),
        .wb_reset_i (rst),
        .cmd_data_i (cmd_data),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .rsp_data_o (rsp_data_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_err_o  (rsp_err_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_data_i  (wb_data_i),
        .wb_we_o    (wb_we_o),
        .wb_cycle_o (wb_cycle_o),
        .wb_strobe_o(wb_strobe_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i)
    );

    typedef struct packed {logic [19:0] addr; logic we; logic [7:0] data;} xfer_t;
    typedef struct packed {logic [7:0] data; logic err;} rsp_t;

    xfer_t       exp_x[$];
    rsp_t        exp_r[$];
    logic [19:0] m_last = 20'h0;
    logic [7:0]  m_hold = 8'h00;
    int          checks = 0;
    int          errors = 0;
    int          rsp_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Transaction-level compare: every strobe cycle must present the head
    // transfer; every response pulse must match the head response.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            m_hold = 8'h00;
        end else begin
            if (wb_strobe_o) begin
                chk("strobe_in_cycle", {31'd0, wb_cycle_o}, 32'd1);
                if (exp_x.size() == 0) begin
                    fail("unexpected_strobe", $sformatf("addr 0x%0h with no transfer expected", wb_addr_o));
                end else begin
                    chk("xfer_addr", {12'd0, wb_addr_o}, {12'd0, exp_x[0].addr});
                    chk("xfer_we", {31'd0, wb_we_o}, {31'd0, exp_x[0].we});
                    if (exp_x[0].we) chk("xfer_data", {24'd0, wb_data_o}, {24'd0, exp_x[0].data});
                    if (!wb_stall_i) void'(exp_x.pop_front());
                end
            end
            if (rsp_valid_o) begin
                rsp_pulses++;
                if (exp_r.size() == 0) begin
                    fail("unexpected_rsp", $sformatf("data 0x%0h err %0d", rsp_data_o, rsp_err_o));
                end else begin
                    chk("rsp_data", {24'd0, rsp_data_o}, {24'd0, exp_r[0].data});
                    chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_r[0].err});
                    m_hold = exp_r[0].data;
                    void'(exp_r.pop_front());
                end
            end else begin
                chk("rsp_hold", {24'd0, rsp_data_o}, {24'd0, m_hold});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("cmd_ready_timeout", $sformatf("byte 0x%0h never accepted", b));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Simple slave: stalls the first stall_n strobe cycles, acks ack_dly
    // cycles after acceptance (or never).
    task automatic bus(input int stall_n, input int ack_dly, input bit give_ack,
                       input logic [7:0] rdata, output int strobes, output int cyc,
                       output logic [19:0] acc_addr);
        int acc;
        acc = -1;
        strobes = 0;
        cyc = 0;
        acc_addr = 20'h0;
        chk("cycle_start", {31'd0, wb_cycle_o}, 32'd1);
        while (wb_cycle_o && cyc < 400) begin
            if (wb_strobe_o) strobes++;
            wb_stall_i = wb_strobe_o && (strobes <= stall_n);
            if (wb_strobe_o && !wb_stall_i) begin
                acc = cyc;
                acc_addr = wb_addr_o;
            end
            wb_ack_i  = give_ack && (acc >= 0) && (cyc - acc == ack_dly);
            wb_data_i = wb_ack_i ? rdata : 8'hC3;
            @(negedge clk);
            cyc++;
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        if (cyc >= 400) fail("cycle_end_timeout", "wb_cycle_o never dropped");
    endtask

    task automatic issue(input logic [7:0] opc, input logic [7:0] ahi, input logic [7:0] alo,
                         input logic [7:0] wd, input int stall_n, input int ack_dly,
                         input bit give_ack, input logic [7:0] rdata,
                         output logic [19:0] acc_addr, output int strobes, output int cyc);
        logic [19:0] a;
        xfer_t x;
        rsp_t r;
        a = opc[7] ? m_last + 20'd1 : {opc[3:0], ahi, alo};
        x = '{addr: a, we: opc[6], data: wd};
        exp_x.push_back(x);
        if (give_ack) begin
            m_last = a;
            if (!opc[6]) begin
                r = '{data: rdata, err: 1'b0};
                exp_r.push_back(r);
            end
        end else begin
            r = '{data: 8'hFF, err: 1'b1};
            exp_r.push_back(r);
        end
        send_byte(opc);
        if (!opc[7]) begin
            send_byte(ahi);
            send_byte(alo);
        end
        if (opc[6]) send_byte(wd);
        bus(stall_n, ack_dly, give_ack, rdata, strobes, cyc, acc_addr);
    endtask

    initial begin
        logic [19:0] aa;
        int st, cy, p0;
        xfer_t x;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_cycle", {31'd0, wb_cycle_o}, 32'd0);
        chk("rst_strobe", {31'd0, wb_strobe_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_addr", {12'd0, wb_addr_o}, 32'd0);
        chk("rst_wdata", {24'd0, wb_data_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_before_edge", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, cmd_ready_o}, 32'd1);

        // WRITE 0x12345 <- 0xA5, ack one cycle after acceptance
        p0 = rsp_pulses;
        issue(8'h41, 8'h23, 8'h45, 8'hA5, 0, 1, 1'b1, 8'h00, aa, st, cy);
        chk("w_addr", {12'd0, aa}, 32'h12345);
        chk("w_strobes", st, 1);
        chk("w_cycles", cy, 2);
        chk("w_ready_back", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clk); #2;
        chk("w_no_rsp", rsp_pulses, p0);

        // READ 0x08000 -> 0x5A
        issue(8'h00, 8'h80, 8'h00, 8'h00, 0, 1, 1'b1, 8'h5A, aa, st, cy);
        chk("r_addr", {12'd0, aa}, 32'h08000);
        chk("r_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("r_rsp_data", {24'd0, rsp_data_o}, 32'h5A);
        chk("r_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        @(negedge clk);
        chk("r_rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);
        chk("r_rsp_held", {24'd0, rsp_data_o}, 32'h5A);

        // Stall 5 cycles: strobe held 6 cycles, one transfer
        issue(8'h41, 8'h23, 8'h46, 8'h77, 5, 1, 1'b1, 8'h00, aa, st, cy);
        chk("stall_strobes", st, 6);
        chk("stall_addr", {12'd0, aa}, 32'h12346);

        // WRITE_NEXT with junk low nibble, ack in the acceptance cycle
        issue(8'hFF, 8'h00, 8'h00, 8'h3C, 0, 0, 1'b1, 8'h00, aa, st, cy);
        chk("wnext_addr", {12'd0, aa}, 32'h12347);
        chk("wnext_cycles", cy, 1);

        // READ with late ack
        issue(8'h0A, 8'hBC, 8'hDE, 8'h00, 0, 3, 1'b1, 8'h99, aa, st, cy);
        chk("late_addr", {12'd0, aa}, 32'hABCDE);
        chk("late_cycles", cy, 4);

        // Address wrap
        issue(8'h4F, 8'hFF, 8'hFF, 8'h11, 0, 1, 1'b1, 8'h00, aa, st, cy);
        chk("top_addr", {12'd0, aa}, 32'hFFFFF);
        issue(8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 1'b1, 8'h22, aa, st, cy);
        chk("wrap_addr", {12'd0, aa}, 32'h00000);

        // Ack while idle is ignored
        @(negedge clk);
        p0 = rsp_pulses;
        wb_ack_i = 1'b1;
        wb_data_i = 8'hEE;
        repeat (3) @(negedge clk);
        wb_ack_i = 1'b0;
        @(negedge clk); #2;
        chk("idle_ack_no_rsp", rsp_pulses, p0);
        chk("idle_ack_hold", {24'd0, rsp_data_o}, 32'h22);

        // Timeout, then READ_NEXT reuses the pre-timeout base
        issue(8'h03, 8'h00, 8'h10, 8'h00, 0, 1, 1'b1, 8'h44, aa, st, cy);
        issue(8'hB5, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 8'h00, aa, st, cy);
        chk("tmo_addr", {12'd0, aa}, 32'h30011);
        chk("tmo_cycles", cy, 255);
        chk("tmo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("tmo_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        chk("tmo_rsp_data", {24'd0, rsp_data_o}, 32'hFF);
        issue(8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 1'b1, 8'h55, aa, st, cy);
        chk("post_tmo_addr", {12'd0, aa}, 32'h30011);

        // Reset while waiting for ack
        x = '{addr: 20'h10203, we: 1'b0, data: 8'h00};
        exp_x.push_back(x);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("pre_rst_strobe", {31'd0, wb_strobe_o}, 32'd1);
        @(negedge clk);
        chk("pre_rst_wait_cycle", {31'd0, wb_cycle_o}, 32'd1);
        chk("pre_rst_wait_strobe", {31'd0, wb_strobe_o}, 32'd0);
        p0 = rsp_pulses;
        rst = 1'b1;
        m_last = 20'h0;
        #1;
        chk("mid_rst_cycle", {31'd0, wb_cycle_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("mid_rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_ready_before_edge", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", {31'd0, cmd_ready_o}, 32'd1);
        repeat (2) @(negedge clk); #2;
        chk("rst_no_rsp", rsp_pulses, p0);

        // Last address cleared by reset
        @(negedge clk);
        issue(8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 1'b1, 8'h66, aa, st, cy);
        chk("after_rst_next_addr", {12'd0, aa}, 32'h00001);

        repeat (3) @(negedge clk); #2;
        chk("xfer_queue_empty", exp_x.size(), 0);
        chk("rsp_queue_empty", exp_r.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_wb_master.md
CMD_WB_MASTER -- requirements
Module: cmd_wb_master

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 20, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data/command byte width.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, max cycles from strobe assertion to ack before abort.
REQ-004 SHALL have one clock and asynchronous active-high reset; all logic clocked on posedge wb_clock_i.
REQ-005 SHALL have port wb_clock_i  input  1  system clock.
REQ-006 SHALL have port wb_reset_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port cmd_data_i  input  8  command stream byte.
REQ-008 SHALL have port cmd_valid_i  input  1  cmd_data_i valid.
REQ-009 SHALL have port cmd_ready_o  output  1  block accepts byte this cycle.
REQ-010 SHALL have port rsp_data_o  output  8  read data or 8'hFF on error.
REQ-011 SHALL have port rsp_valid_o  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_err_o  output  1  response is a timeout, qualified by rsp_valid_o.
REQ-013 SHALL have ports wb_addr_o (output 20), wb_data_o (output 8), wb_data_i (input 8), wb_we_o, wb_cycle_o, wb_strobe_o (outputs 1), wb_stall_i, wb_ack_i (inputs 1): Wishbone B4 pipelined controller.

Function
REQ-014 SHALL accept a byte only on a cycle with cmd_valid_i & cmd_ready_o.
REQ-015 SHALL decode opcode byte: bits[7:6] op (00 READ, 01 WRITE, 10 READ_NEXT, 11 WRITE_NEXT), bits[3:0] addr[19:16], bits[5:4] ignored.
REQ-016 SHALL, for READ/WRITE, take two further bytes addr[15:8] then addr[7:0]; opcode addr[19:16] loaded at opcode acceptance.
REQ-017 SHALL, for READ_NEXT/WRITE_NEXT, use last transferred address + 1 modulo 2^20 (20'hFFFFF wraps to 20'h00000), ignoring opcode bits[3:0].
REQ-018 SHALL, for WRITE/WRITE_NEXT, take one data byte after address bytes (immediately after opcode for WRITE_NEXT).
REQ-019 SHALL use states IDLE, ADDR_HI, ADDR_LO, DATA, STROBE, WAIT_ACK; cmd_ready_o high only in IDLE, ADDR_HI, ADDR_LO, DATA.
REQ-020 SHALL enter STROBE the cycle after the final command byte is accepted, driving wb_cycle_o=1, wb_strobe_o=1, wb_addr_o, wb_we_o, wb_data_o stable.
REQ-021 SHALL hold wb_strobe_o while wb_stall_i=1; the cycle with strobe & ~stall is the acceptance cycle; next cycle wb_strobe_o=0 and state WAIT_ACK with wb_cycle_o=1.
REQ-022 SHALL treat wb_ack_i sampled in the acceptance cycle or any later cycle as completion; next cycle wb_cycle_o=0, state IDLE, cmd_ready_o=1.
REQ-023 SHALL, on READ completion, capture wb_data_i in the ack cycle and pulse rsp_valid_o=1, rsp_err_o=0 for exactly one cycle, same cycle as return to IDLE.
REQ-024 SHALL produce no response for writes completed normally.
REQ-025 SHALL count cycles from STROBE entry; if ACK_TIMEOUT cycles elapse without ack, deassert wb_cycle_o/wb_strobe_o next cycle, return to IDLE, pulse rsp_valid_o=1, rsp_err_o=1, rsp_data_o=8'hFF (reads and writes).
REQ-026 SHALL update the "last address" register only on normal completion, not on timeout.
REQ-027 SHALL ignore wb_ack_i outside STROBE/WAIT_ACK.
REQ-028 SHALL hold rsp_data_o stable until next response.

Reset
REQ-029 SHALL, while wb_reset_i=1, immediately force state IDLE, cmd_ready_o=0, wb_cycle_o=0, wb_strobe_o=0, wb_we_o=0, wb_addr_o=0, wb_data_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, last address=0, timeout counter=0.
REQ-030 SHALL raise cmd_ready_o on the first clock edge after reset release.
REQ-031 SHALL, on reset mid-transaction, abandon it with no response pulse and discard partial command bytes.

Verification
REQ-032 SHALL verify: WRITE 0x41,0x23,0x45,0xA5 with stall=0, ack one cycle after acceptance -> single strobe addr 0x12345, we=1, data 0xA5; no rsp_valid_o.
REQ-033 SHALL verify: READ 0x00,0x80,0x00, wb_data_i=0x5A at ack -> rsp_valid_o one cycle, rsp_data_o=0x5A, rsp_err_o=0.
REQ-034 SHALL verify: wb_stall_i=1 for 5 cycles -> strobe held 6 cycles, addr/data unchanged, exactly one transfer.
REQ-035 SHALL verify: after access at 0xFFFFF, READ_NEXT 0x80 -> wb_addr_o=0x00000.
REQ-036 SHALL verify: no ack -> after 255 cycles cycle/strobe drop, rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0xFF; following READ_NEXT reuses pre-timeout base+1.
REQ-037 SHALL verify: reset asserted during WAIT_ACK -> wb_cycle_o=0 immediately, no rsp_valid_o, cmd_ready_o=1 one edge after release.
